// File: rtl/cam_dvp_pkg.sv
// Shared definitions for the camera parallel pixel port: pattern codes and colour-bar bytes.
// Used by the sensor emulator and by the capture side.
package cam_dvp_pkg;

    typedef logic [1:0] pattern_t;

    localparam pattern_t PAT_COUNT = 2'd0;
    localparam pattern_t PAT_BARS  = 2'd1;
    localparam pattern_t PAT_ROWS  = 2'd2;
    localparam pattern_t PAT_CHECK = 2'd3;

    // Index 0 is the leftmost bar: FF, E0, 1C, 03, FC, 1F, E3, 00.
    localparam logic [7:0][7:0] BAR_TABLE = {
        8'h00, 8'hE3, 8'h1F, 8'hFC, 8'h03, 8'h1C, 8'hE0, 8'hFF
    };

    function automatic logic [7:0] bar_byte(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern byte select from the pattern code, horizontal byte
// position, active row and colour-bar index.
module cam_pattern_gen
    import cam_dvp_pkg::*;
(
    input  logic [1:0] pattern,
    input  logic [7:0] h_byte,
    input  logic [7:0] row,
    input  logic [2:0] bar,
    output logic [7:0] pixel
);

    always_comb begin
        pixel = 8'h00;
        case (pattern)
            PAT_COUNT: pixel = h_byte;
            PAT_BARS:  pixel = bar_byte(bar);
            PAT_ROWS:  pixel = row;
            default:   pixel = (h_byte[4] ^ row[4]) ? 8'hFF : 8'h00;
        endcase
    end

endmodule

// File: rtl/cam_sensor_emu.sv
// Camera sensor parallel-port emulator: Pclk = clk/2, frame/line timing and a
// selectable test pattern; all non-Pclk state advances on Pclk falling edges.
module cam_sensor_emu
    import cam_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 288,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_ACTIVE    = 480,
    parameter int V_FRONT     = 10,
    parameter int BAR_W       = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pattern_sel,
    output logic       Pclk,
    output logic       Vsync,
    output logic       Href,
    output logic [7:0] Imagen,
    output logic       frame_done
);

    localparam int H_TOTAL     = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL     = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int H_W         = $clog2(H_TOTAL);
    localparam int V_W         = $clog2(V_TOTAL);
    localparam int V_ACT_START = VSYNC_LINES + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int BW_W        = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic            pclk_reg;
    logic            state_reg, state_next;
    logic [H_W-1:0]  h_reg, h_next;
    logic [V_W-1:0]  v_reg, v_next;
    logic [2:0]      bar_reg, bar_next;
    logic [BW_W-1:0] bar_pos_reg, bar_pos_next;
    logic [1:0]      pattern_reg, pattern_next;
    logic            vsync_reg, vsync_next;
    logic            href_reg, href_next;
    logic [7:0]      imagen_reg, imagen_next;
    logic            frame_done_reg, done_next;

    logic            h_last, v_last;
    logic            run_next;
    logic [7:0]      h_byte, row_byte, pixel;

    assign h_last = (h_reg == H_W'(H_TOTAL - 1));
    assign v_last = (v_reg == V_W'(V_TOTAL - 1));

    always_comb begin
        state_next   = state_reg;
        h_next       = h_reg;
        v_next       = v_reg;
        pattern_next = pattern_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    state_next   = ST_RUN;
                    h_next       = '0;
                    v_next       = '0;
                    pattern_next = pattern_sel;
                end
            end
            default: begin
                if (h_last && v_last) begin
                    done_next = 1'b1;
                    h_next    = '0;
                    v_next    = '0;
                    if (en) begin
                        pattern_next = pattern_sel;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (h_last) begin
                    h_next = '0;
                    v_next = v_reg + 1'b1;
                end else begin
                    h_next = h_reg + 1'b1;
                end
            end
        endcase
    end

    // Bar index tracks the byte about to be presented; restarts with every line.
    always_comb begin
        bar_next     = bar_reg;
        bar_pos_next = bar_pos_reg;
        if (h_next == '0) begin
            bar_next     = 3'd0;
            bar_pos_next = '0;
        end else if (bar_pos_reg == BW_W'(BAR_W - 1)) begin
            bar_next     = bar_reg + 3'd1;
            bar_pos_next = '0;
        end else begin
            bar_pos_next = bar_pos_reg + 1'b1;
        end
    end

    assign run_next   = (state_next == ST_RUN);
    assign vsync_next = run_next && (v_next < V_W'(VSYNC_LINES));
    assign href_next  = run_next
                     && ({1'b0, v_next} >= (V_W + 1)'(V_ACT_START))
                     && ({1'b0, v_next} <  (V_W + 1)'(V_ACT_END))
                     && ({1'b0, h_next} <  (H_W + 1)'(H_ACTIVE));
    assign h_byte     = 8'(h_next);
    assign row_byte   = 8'(v_next - V_W'(V_ACT_START));

    cam_pattern_gen u_pattern_gen (
        .pattern (pattern_next),
        .h_byte  (h_byte),
        .row     (row_byte),
        .bar     (bar_next),
        .pixel   (pixel)
    );

    assign imagen_next = href_next ? pixel : 8'h00;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_reg       <= 1'b0;
            state_reg      <= ST_IDLE;
            h_reg          <= '0;
            v_reg          <= '0;
            bar_reg        <= '0;
            bar_pos_reg    <= '0;
            pattern_reg    <= '0;
            vsync_reg      <= 1'b0;
            href_reg       <= 1'b0;
            imagen_reg     <= 8'h00;
            frame_done_reg <= 1'b0;
        end else begin
            pclk_reg       <= ~pclk_reg;
            frame_done_reg <= 1'b0;
            // pclk_reg high means this edge drives Pclk low: the update edge.
            if (pclk_reg) begin
                state_reg      <= state_next;
                h_reg          <= h_next;
                v_reg          <= v_next;
                bar_reg        <= bar_next;
                bar_pos_reg    <= bar_pos_next;
                pattern_reg    <= pattern_next;
                vsync_reg      <= vsync_next;
                href_reg       <= href_next;
                imagen_reg     <= imagen_next;
                frame_done_reg <= done_next;
            end
        end
    end

    assign Pclk       = pclk_reg;
    assign Vsync      = vsync_reg;
    assign Href       = href_reg;
    assign Imagen     = imagen_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_cam_sensor_emu.sv
// Scoreboard bench: a frame-level model (period index -> h, v, byte) predicts every
// clk of two emulator instances (8- and 32-byte lines); monitors compare at negedge.
`timescale 1ns/1ps
module tb_cam_sensor_emu;

    localparam int HB   = 4;
    localparam int VSL  = 1;
    localparam int VB   = 1;
    localparam int VA   = 4;
    localparam int VF   = 1;
    localparam int BW   = 2;
    localparam int HA_A = 8;
    localparam int HA_B = 32;
    localparam int FT_A = (HA_A + HB) * (VSL + VB + VA + VF);
    localparam int FT_B = (HA_B + HB) * (VSL + VB + VA + VF);

    typedef struct {
        bit run;
        int p;
        int pat;
        bit pclk;
        bit fd;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;

    logic       pclk_a, vsync_a, href_a, fd_a;
    logic [7:0] img_a;
    logic       pclk_b, vsync_b, href_b, fd_b;
    logic [7:0] img_b;

    int errors = 0;
    int checks = 0;
    int fd_exp_a = 0, fd_exp_b = 0;
    int fd_seen_a = 0, fd_seen_b = 0;
    int cyc = 0;

    logic [11:0] q_a[$];
    logic [11:0] q_b[$];
    mstate_t sa = '{run: 0, p: 0, pat: 0, pclk: 0, fd: 0};
    mstate_t sb = '{run: 0, p: 0, pat: 0, pclk: 0, fd: 0};

    always #5 clk = ~clk;

    cam_sensor_emu #(
        .H_ACTIVE(HA_A), .H_BLANK(HB), .VSYNC_LINES(VSL), .V_BACK(VB),
        .V_ACTIVE(VA), .V_FRONT(VF), .BAR_W(BW)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(sel),
        .Pclk(pclk_a), .Vsync(vsync_a), .Href(href_a), .Imagen(img_a),
        .frame_done(fd_a)
    );

    cam_sensor_emu #(
        .H_ACTIVE(HA_B), .H_BLANK(HB), .VSYNC_LINES(VSL), .V_BACK(VB),
        .V_ACTIVE(VA), .V_FRONT(VF), .BAR_W(BW)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(sel),
        .Pclk(pclk_b), .Vsync(vsync_b), .Href(href_b), .Imagen(img_b),
        .frame_done(fd_b)
    );

    // One clk of sensor behaviour: frame position is a single period index.
    function automatic mstate_t m_step(mstate_t s, bit r, bit e, int pat_in, int ft);
        mstate_t n;
        n = s;
        n.fd = 1'b0;
        if (r) begin
            n.run = 1'b0; n.p = 0; n.pat = 0; n.pclk = 1'b0;
            return n;
        end
        n.pclk = ~s.pclk;
        if (s.pclk) begin
            if (!s.run) begin
                if (e) begin
                    n.run = 1'b1; n.p = 0; n.pat = pat_in;
                end
            end else if (s.p == ft - 1) begin
                n.fd = 1'b1;
                n.p = 0;
                if (e) n.pat = pat_in;
                else   n.run = 1'b0;
            end else begin
                n.p = s.p + 1;
            end
        end
        return n;
    endfunction

    // Expected {Pclk, Vsync, Href, Imagen, frame_done}.
    function automatic logic [11:0] m_out(mstate_t s, int ha);
        logic [7:0] tbl [8];
        int ht, h, v, row;
        bit vs, hr;
        logic [7:0] b;
        tbl = '{8'hFF, 8'hE0, 8'h1C, 8'h03, 8'hFC, 8'h1F, 8'hE3, 8'h00};
        vs = 1'b0; hr = 1'b0; b = 8'h00;
        if (s.run) begin
            ht  = ha + HB;
            h   = s.p % ht;
            v   = s.p / ht;
            row = v - (VSL + VB);
            vs  = (v < VSL);
            hr  = (v >= VSL + VB) && (v < VSL + VB + VA) && (h < ha);
            case (s.pat)
                0:       b = 8'(h);
                1:       b = tbl[(h / BW) % 8];
                2:       b = 8'(row);
                default: b = ((((h >> 4) ^ (row >> 4)) & 1) != 0) ? 8'hFF : 8'h00;
            endcase
            if (!hr) b = 8'h00;
        end
        return {s.pclk, vs, hr, b, s.fd};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got pclk=%b vs=%b href=%b img=%02h fd=%b expected pclk=%b vs=%b href=%b img=%02h fd=%b",
                     name, cyc, act[11], act[10], act[9], act[8:1], act[0],
                     exp[11], exp[10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    // Model: advance at each posedge from the same inputs the DUTs sample.
    always @(posedge clk) begin
        sa = m_step(sa, rst, en, int'(sel), FT_A);
        sb = m_step(sb, rst, en, int'(sel), FT_B);
        if (sa.fd) fd_exp_a++;
        if (sb.fd) fd_exp_b++;
        q_a.push_back(m_out(sa, HA_A));
        q_b.push_back(m_out(sb, HA_B));
    end

    // Monitors: pop one expected record per DUT output update.
    always @(negedge clk) begin
        logic [11:0] e;
        cyc++;
        if (fd_a === 1'b1) fd_seen_a++;
        if (fd_b === 1'b1) fd_seen_b++;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("port_a", {pclk_a, vsync_a, href_a, img_a, fd_a}, e);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("port_b", {pclk_b, vsync_b, href_b, img_b, fd_b}, e);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; sel = 2'd0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        // COUNT frame, pattern switched to ROWS mid-frame
        repeat (80) @(negedge clk);
        sel = 2'd2;
        repeat (200) @(negedge clk);
        sel = 2'd1;
        repeat (170) @(negedge clk);
        sel = 2'd3;
        repeat (520) @(negedge clk);
        // en dropped mid-frame: frames finish, then idle
        en = 1'b0;
        repeat (700) @(negedge clk);
        en = 1'b1; sel = 2'd3;
        repeat (300) @(negedge clk);
        // mid-frame reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; sel = 2'd1;
        repeat (600) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end
        rst = 1'b0; en = 1'b1;
        repeat (1100) @(negedge clk);
        en = 1'b0;
        repeat (1100) @(negedge clk);
        checks++;
        if (fd_seen_a != fd_exp_a) begin
            errors++;
            $display("FAIL frame_count_a got %0d expected %0d", fd_seen_a, fd_exp_a);
        end
        checks++;
        if (fd_seen_b != fd_exp_b) begin
            errors++;
            $display("FAIL frame_count_b got %0d expected %0d", fd_seen_b, fd_exp_b);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
